ddr4_odt_gen: RTL



---
 rtl/ddr4_phy_pkg.sv | 12 +
 rtl/ddr4_odt_window.sv | 53 +++++
 rtl/ddr4_odt_gen.sv | 64 ++++++
 3 files changed

// File: rtl/ddr4_phy_pkg.sv
// ddr4_phy_pkg: shared DDR4 PHY constants, ODT FSM states and the ODT command-mask helper.
package ddr4_phy_pkg;
  localparam int GEAR_RATIO = 4;
  localparam int MASK_W = 64;
  typedef enum logic [1:0] {INIT, PARK, ACTIVE} odt_state_t;
  // Bit 0 of the mask is the first DRAM clock of the next fabric cycle; lat must already be >= GEAR_RATIO.
  function automatic logic [MASK_W-1:0] odt_mask(input logic [1:0] slot, input logic [5:0] lat, input logic [7:0] len);
    logic [MASK_W-1:0] ones;
    ones = (MASK_W'(1) << len) - MASK_W'(1);
    return ones << (7'(slot) + 7'(lat) - 7'(GEAR_RATIO));
  endfunction
endpackage

// File: rtl/ddr4_odt_window.sv
// ddr4_odt_window: ODT window shift register with OR-merge of new command masks.
// ODT_OVERLAP_ERR_EN adds a sticky flag for commands whose mask collides with the pending window.
module ddr4_odt_window
  import ddr4_phy_pkg::*;
#(
  parameter int MAX_LAT = 32,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd,
  input  logic [1:0]       slot,
  input  logic [5:0]       lat,
  input  logic [LEN_W-1:0] len,
  output logic [3:0]       tx,
  output logic             busy,
  output logic             idle_nxt,
  output logic             take
`ifdef ODT_OVERLAP_ERR_EN
  ,input logic             err_clr,
  output logic             err
`endif
);
  localparam int WW = MAX_LAT + 2**LEN_W + 4;
  logic [WW-1:0] w, w_nxt, mask;
  logic [5:0] lat_c;
  logic [3:0] tx_nxt;
  always_comb begin
    lat_c = lat < 6'd4 ? 6'd4 : lat > 6'(MAX_LAT) ? 6'(MAX_LAT) : lat;
    take = cmd & |len;
    mask = take ? WW'(odt_mask(slot, lat_c, 8'(len))) : '0;
    tx_nxt = w[3:0] | mask[3:0];
    w_nxt = (w >> 4) | (mask >> 4);
    idle_nxt = ~|w_nxt & ~|tx_nxt;
  end
  assign busy = |w | |tx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0;
      tx <= '0;
    end else begin
      w <= w_nxt;
      tx <= tx_nxt;
    end
  end
`ifdef ODT_OVERLAP_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (|(mask & w)) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`endif
endmodule

// File: rtl/ddr4_odt_gen.sv
// ddr4_odt_gen: 4:1-geared ODT waveform generator for the DDR4 ODT0 IOD lane.
// ODT_OVERLAP_ERR_EN adds ERR_CLR / ERR_OVERLAP for overlapping ODT windows.
module ddr4_odt_gen
  import ddr4_phy_pkg::*;
#(
  parameter int MAX_LAT = 32,
  parameter int LEN_W = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             WR_CMD_VALID,
  input  logic [1:0]       WR_CMD_SLOT,
  input  logic [5:0]       CFG_ODT_LAT,
  input  logic [LEN_W-1:0] CFG_ODT_LEN,
  output logic [3:0]       TX_DATA_0,
  output logic [3:0]       OE_DATA_0,
  output logic             ODT_EN_0,
  output logic             BUSY
`ifdef ODT_OVERLAP_ERR_EN
  ,input logic             ERR_CLR,
  output logic             ERR_OVERLAP
`endif
);
  localparam int CW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
  odt_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0] tx;
  logic idle_nxt, take;
  ddr4_odt_window #(.MAX_LAT(MAX_LAT), .LEN_W(LEN_W)) u_window (
    .clk(FAB_CLK),
    .rst(ARST),
    .cmd(WR_CMD_VALID & (state != INIT)),
    .slot(WR_CMD_SLOT),
    .lat(CFG_ODT_LAT),
    .len(CFG_ODT_LEN),
    .tx(tx),
    .busy(BUSY),
    .idle_nxt(idle_nxt),
    .take(take)
`ifdef ODT_OVERLAP_ERR_EN
    ,.err_clr(ERR_CLR),
    .err(ERR_OVERLAP)
`endif
  );
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state == INIT ? cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == INIT) state_nxt = cnt == CW'(INIT_CYCLES - 1) ? PARK : INIT;
    else if (take) state_nxt = ACTIVE;
    else if (state == ACTIVE && idle_nxt) state_nxt = PARK;
  end
  assign TX_DATA_0 = state == ACTIVE ? tx : 4'b0000;
  assign OE_DATA_0 = state == INIT ? 4'b0000 : 4'b1111;
  assign ODT_EN_0 = 1'b0;
endmodule
